ex_operand_stage: RTL
=====================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register that feeds the execute-stage ALU. It presents the ALU with registered `a`, `b` and `aluc` values.
- Selects operands before the register: register value, immediate or shift amount, with EX/MEM and MEM/WB forwarding applied first.
- Detects load-use hazards, inserts a bubble and requests a decode stall.
- Sits between the decode stage / register file and the ALU plus EX/MEM register.

Parameters:
DATA_W, 32, datapath width
REG_AW, 5, register index width
ALUC_W, 4, ALU control code width

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  decode slot holds a real instruction
id_rs_val  in  DATA_W  register-file read of rs
id_rt_val  in  DATA_W  register-file read of rt
id_rs  in  REG_AW  rs index
id_rt  in  REG_AW  rt index
id_use_rs  in  1  instruction reads rs
id_use_rt  in  1  instruction reads rt
id_imm  in  16  raw immediate
id_shamt  in  5  shift amount field
id_sign_ext  in  1  1 = sign-extend imm, 0 = zero-extend
id_a_sel  in  1  0 = rs, 1 = {27'b0, shamt}
id_b_sel  in  1  0 = rt, 1 = extended imm
id_aluc  in  ALUC_W  ALU op code
id_dest  in  REG_AW  destination register
id_wr_en  in  1  instruction writes dest
id_mem_read  in  1  instruction is a load
fwd1_we  in  1  EX/MEM result valid for write
fwd1_addr  in  REG_AW  EX/MEM dest
fwd1_data  in  DATA_W  EX/MEM result
fwd2_we  in  1  MEM/WB write enable
fwd2_addr  in  REG_AW  MEM/WB dest
fwd2_data  in  DATA_W  MEM/WB write data
ex_hold  in  1  downstream stall; freeze this register
flush  in  1  squash the instruction being captured (branch/jump)
stall_req  out  1  combinational; decode must hold PC and IF/ID
ex_valid  out  1  registered instruction valid
ex_a  out  DATA_W  ALU operand a
ex_b  out  DATA_W  ALU operand b
ex_aluc  out  ALUC_W  ALU op code
ex_rt_fwd  out  DATA_W  forwarded rt (store data)
ex_dest  out  REG_AW  dest index
ex_wr_en  out  1  write enable, already gated by valid
ex_mem_read  out  1  load flag, already gated by valid
bubble_cnt  out  16  saturating count of inserted load-use bubbles

Behaviour:
- Reset (`rst_n` low, async): every registered output is 0, including `ex_valid`, `ex_wr_en`, `ex_mem_read` and `bubble_cnt`. Release is sampled at the next clk edge.
- Latency: 1 cycle from decode inputs to `ex_*`.
- Forwarding per source operand (rs, rt):
  - fwd1 takes priority over fwd2, which takes priority over the register-file value.
  - A source matches only if `we=1`, `addr==index` and `index!=0`.
  - Register 0 always reads 0 regardless of inputs.
- Operand a: forwarded rs, or `{27'b0, id_shamt}` when `id_a_sel=1`. The ALU shift ops take the shift amount on `a` and the value on `b`.
- Operand b: forwarded rt, or the extended immediate when `id_b_sel=1`. Sign extension replicates `imm[15]`; zero extension pads with 0. LUI is passed as the extended immediate; the ALU performs the shift.
- `ex_rt_fwd` always carries the forwarded rt, regardless of `b_sel`.
- Load-use hazard: `hz = ex_valid & ex_mem_read & ex_dest!=0 & ((id_use_rs & id_rs==ex_dest) | (id_use_rt & id_rt==ex_dest)) & id_valid`.
- `stall_req = hz & ~ex_hold`. When `ex_hold=1`, `stall_req` is 0 because decode is already frozen by the global stall.
- Next-state priority at each clk edge:
  1. `ex_hold`: all registers keep their value, including under `flush`. Flush is re-asserted by control after the hold.
  2. `flush`: load a bubble (`valid`, `wr_en`, `mem_read` = 0; data fields 0).
  3. `hz`: load a bubble; `bubble_cnt` increments, saturating at 0xFFFF.
  4. Otherwise capture decode; `wr_en` and `mem_read` are ANDed with `id_valid`.
- `id_valid=0` is captured as a bubble but does not count toward `bubble_cnt`.
- A bubble never matches the hazard check, because `ex_valid=0`.
- Reset mid-stall clears all state; `stall_req` drops immediately because `ex_valid=0`.

Optional Feature:
- Macro: `EX_FWD_EN`.
- Defined: fwd1/fwd2 bypass is active exactly as above.
- Undefined:
  - No data bypass: operands come straight from the register file.
  - The hazard condition widens to any RAW (read-after-write) match against the EX register (`ex_valid & ex_wr_en`), fwd1 or fwd2. The `mem_read` requirement is dropped.
  - A bubble is inserted each cycle the match persists; `bubble_cnt` counts every such bubble.
  - `fwd*_data` ports remain but are unused.

Decomposition:
- Shared package/def include holds:
  - `DATA_W`, `REG_AW`, `ALUC_W`
  - the existing 4-bit ALU op codes
  - `A_SEL_RS`/`A_SEL_SHAMT` and `B_SEL_RT`/`B_SEL_IMM` constants
- One sub-module, `fwd_mux`: combinational per-operand forwarding selector, instantiated twice (rs, rt).

Test Plan:
- Reset: hold `rst_n`=0 mid-cycle with valid inputs -> all `ex_*`=0, `bubble_cnt`=0 asynchronously.
- ADDI with rs=$3=0x0000_0005, imm=0xFFFF, `sign_ext`=1 -> next cycle `ex_a`=5, `ex_b`=0xFFFF_FFFF, `ex_wr_en`=1.
- Forwarding:
  - fwd1 ($3, 0x11) and fwd2 ($3, 0x22) both active, `id_rs`=3 -> `ex_a`=0x11.
  - `id_rs`=0 with fwd1_addr=0 -> `ex_a`=0.
- Load-use: LW $4 in EX, next instruction reads rt=$4 -> `stall_req`=1 for one cycle, bubble inserted, `bubble_cnt`=1; the following cycle captures normally.
- Hold vs flush: `ex_hold`=1 and `flush`=1 together -> registers unchanged. Then `ex_hold`=0, `flush`=1 -> `ex_valid`=0.
- SLL: shamt=4, `a_sel`=1, rt=0x0000_000F -> `ex_a`=4, `ex_b`=0xF. Without `EX_FWD_EN`, RAW on fwd1 dest -> `stall_req`=1 until fwd1_we clears.

Source files
------------

// File: rtl/ex_operand_stage_pkg.sv
// Shared widths, ALU op codes, operand-select codes and the ID/EX register payload.
package ex_operand_stage_pkg;

   localparam int unsigned DATA_W  = 32;
   localparam int unsigned REG_AW  = 5;
   localparam int unsigned ALUC_W  = 4;
   localparam int unsigned IMM_W   = 16;
   localparam int unsigned SHAMT_W = 5;
   localparam int unsigned CNT_W   = 16;

   // Execute-stage ALU operation codes
   typedef enum logic [ALUC_W-1:0] {
      ALU_ADD = 4'h0,
      ALU_SUB = 4'h1,
      ALU_AND = 4'h2,
      ALU_OR  = 4'h3,
      ALU_XOR = 4'h4,
      ALU_LUI = 4'h5,
      ALU_SLL = 4'h6,
      ALU_SRL = 4'h7,
      ALU_SRA = 4'h8,
      ALU_SLT = 4'h9
   } alu_op_e;

   localparam logic A_SEL_RS    = 1'b0;
   localparam logic A_SEL_SHAMT = 1'b1;
   localparam logic B_SEL_RT    = 1'b0;
   localparam logic B_SEL_IMM   = 1'b1;

   // ID/EX register contents
   typedef struct packed {
      logic              valid;
      logic              wr_en;
      logic              mem_read;
      logic [ALUC_W-1:0] aluc;
      logic [REG_AW-1:0] dest;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [DATA_W-1:0] rt_fwd;
   } ex_reg_t;

   // Sign- or zero-extend the 16-bit immediate to the datapath width
   function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm,
                                                 input logic             sign);
      return sign ? {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm}
                  : {{(DATA_W-IMM_W){1'b0}}, imm};
   endfunction

endpackage

// File: rtl/ex_operand_stage_fwd_mux.sv
// Per-operand bypass selector: EX/MEM over MEM/WB over register file; r0 reads 0.
module fwd_mux
   import ex_operand_stage_pkg::*;
(
   input  logic [REG_AW-1:0] i_idx,
   input  logic [DATA_W-1:0] i_rf_val,
   input  logic              i_fwd1_we,
   input  logic [REG_AW-1:0] i_fwd1_addr,
   input  logic [DATA_W-1:0] i_fwd1_data,
   input  logic              i_fwd2_we,
   input  logic [REG_AW-1:0] i_fwd2_addr,
   input  logic [DATA_W-1:0] i_fwd2_data,
   output logic [DATA_W-1:0] o_val_c
);

   // Priority select of the freshest copy of the register
   always_comb begin
      o_val_c = i_rf_val;
      if (i_idx == '0)
         o_val_c = '0;
      else if (i_fwd1_we && (i_fwd1_addr == i_idx))
         o_val_c = i_fwd1_data;
      else if (i_fwd2_we && (i_fwd2_addr == i_idx))
         o_val_c = i_fwd2_data;
   end

endmodule

// File: rtl/ex_operand_stage.sv
// ID/EX operand register: forwarding, operand select, load-use bubble insertion.
// Build option: EX_FWD_EN enables EX/MEM and MEM/WB bypass; without it any RAW
// match against EX, fwd1 or fwd2 stalls decode instead.
module ex_operand_stage
   import ex_operand_stage_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [DATA_W-1:0] id_rs_val,
   input  logic [DATA_W-1:0] id_rt_val,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic [IMM_W-1:0]  id_imm,
   input  logic [SHAMT_W-1:0] id_shamt,
   input  logic              id_sign_ext,
   input  logic              id_a_sel,
   input  logic              id_b_sel,
   input  logic [ALUC_W-1:0] id_aluc,
   input  logic [REG_AW-1:0] id_dest,
   input  logic              id_wr_en,
   input  logic              id_mem_read,
   input  logic              fwd1_we,
   input  logic [REG_AW-1:0] fwd1_addr,
   input  logic [DATA_W-1:0] fwd1_data,
   input  logic              fwd2_we,
   input  logic [REG_AW-1:0] fwd2_addr,
   input  logic [DATA_W-1:0] fwd2_data,
   input  logic              ex_hold,
   input  logic              flush,
   output logic              stall_req,
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [ALUC_W-1:0] ex_aluc,
   output logic [DATA_W-1:0] ex_rt_fwd,
   output logic [REG_AW-1:0] ex_dest,
   output logic              ex_wr_en,
   output logic              ex_mem_read,
   output logic [CNT_W-1:0]  bubble_cnt
);

   ex_reg_t             r_ex;
   ex_reg_t             w_nxt;
   logic [CNT_W-1:0]    r_bubble_cnt;
   logic [CNT_W-1:0]    w_cnt_nxt;
   logic [DATA_W-1:0]   w_rs_fwd;
   logic [DATA_W-1:0]   w_rt_fwd;
   logic [DATA_W-1:0]   w_a;
   logic [DATA_W-1:0]   w_b;
   logic                w_byp1_we;
   logic                w_byp2_we;
   logic                w_hz;

`ifdef EX_FWD_EN
   assign w_byp1_we = fwd1_we;
   assign w_byp2_we = fwd2_we;
`else
   assign w_byp1_we = 1'b0;
   assign w_byp2_we = 1'b0;
`endif

   fwd_mux u_fwd_rs (
      .i_idx       (id_rs),
      .i_rf_val    (id_rs_val),
      .i_fwd1_we   (w_byp1_we),
      .i_fwd1_addr (fwd1_addr),
      .i_fwd1_data (fwd1_data),
      .i_fwd2_we   (w_byp2_we),
      .i_fwd2_addr (fwd2_addr),
      .i_fwd2_data (fwd2_data),
      .o_val_c     (w_rs_fwd)
   );

   fwd_mux u_fwd_rt (
      .i_idx       (id_rt),
      .i_rf_val    (id_rt_val),
      .i_fwd1_we   (w_byp1_we),
      .i_fwd1_addr (fwd1_addr),
      .i_fwd1_data (fwd1_data),
      .i_fwd2_we   (w_byp2_we),
      .i_fwd2_addr (fwd2_addr),
      .i_fwd2_data (fwd2_data),
      .o_val_c     (w_rt_fwd)
   );

   // Hazard detection: load-use with bypass, any RAW without it
   always_comb begin
      w_hz = 1'b0;
`ifdef EX_FWD_EN
      w_hz = id_valid && r_ex.valid && r_ex.mem_read && (r_ex.dest != '0) &&
             ((id_use_rs && (id_rs == r_ex.dest)) ||
              (id_use_rt && (id_rt == r_ex.dest)));
`else
      w_hz = id_valid &&
             ((id_use_rs && (id_rs != '0) &&
               ((r_ex.valid && r_ex.wr_en && (r_ex.dest == id_rs)) ||
                (fwd1_we && (fwd1_addr == id_rs)) ||
                (fwd2_we && (fwd2_addr == id_rs)))) ||
              (id_use_rt && (id_rt != '0) &&
               ((r_ex.valid && r_ex.wr_en && (r_ex.dest == id_rt)) ||
                (fwd1_we && (fwd1_addr == id_rt)) ||
                (fwd2_we && (fwd2_addr == id_rt)))));
`endif
   end

   assign stall_req = w_hz && !ex_hold;

   // Operand select after forwarding
   always_comb begin
      w_a = w_rs_fwd;
      w_b = w_rt_fwd;
      case (id_a_sel)
         A_SEL_RS:    w_a = w_rs_fwd;
         A_SEL_SHAMT: w_a = {{(DATA_W-SHAMT_W){1'b0}}, id_shamt};
      endcase
      case (id_b_sel)
         B_SEL_RT:  w_b = w_rt_fwd;
         B_SEL_IMM: w_b = ext_imm(id_imm, id_sign_ext);
      endcase
   end

   // Next-state: hold, then flush, then hazard bubble, else capture decode
   always_comb begin
      w_nxt     = r_ex;
      w_cnt_nxt = r_bubble_cnt;
      if (!ex_hold) begin
         if (flush) begin
            w_nxt = '0;
         end else if (w_hz) begin
            w_nxt = '0;
            if (r_bubble_cnt != '1)
               w_cnt_nxt = r_bubble_cnt + CNT_W'(1);
         end else begin
            w_nxt.valid    = id_valid;
            w_nxt.wr_en    = id_wr_en && id_valid;
            w_nxt.mem_read = id_mem_read && id_valid;
            w_nxt.aluc     = id_aluc;
            w_nxt.dest     = id_dest;
            w_nxt.a        = w_a;
            w_nxt.b        = w_b;
            w_nxt.rt_fwd   = w_rt_fwd;
         end
      end
   end

   // ID/EX register and bubble counter
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ex         <= '0;
         r_bubble_cnt <= '0;
      end else begin
         r_ex         <= w_nxt;
         r_bubble_cnt <= w_cnt_nxt;
      end
   end

   assign ex_valid    = r_ex.valid;
   assign ex_a        = r_ex.a;
   assign ex_b        = r_ex.b;
   assign ex_aluc     = r_ex.aluc;
   assign ex_rt_fwd   = r_ex.rt_fwd;
   assign ex_dest     = r_ex.dest;
   assign ex_wr_en    = r_ex.wr_en;
   assign ex_mem_read = r_ex.mem_read;
   assign bubble_cnt  = r_bubble_cnt;

endmodule
